punc_control: RTL and testbench

Multi-cycle FSM controller for the PUnC LC3 processor. It sits directly upstream of the datapath. It consumes the instruction register and the N/Z/P condition codes, and drives every datapath enable and mux select. Each instruction runs through FETCH, DECODE and EXECUTE; LDI and STI take one extra cycle.

---
 rtl/punc_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_punc_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control.sv
// PUnC LC3 multi-cycle controller: FETCH/DECODE/EXEC(/EXEC2), HALT; PUNC_ILLEGAL_HALT_EN traps reserved opcodes 1000/1101.
// Latency 3 cycles per instruction (LDI/STI 4); no backpressure, outputs are combinational from state and ir.
module punc_control #(
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        ldi_reg_ld,
`ifdef PUNC_ILLEGAL_HALT_EN
    output logic        illegal,
`endif
    output logic        halted
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADDI = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_ANDI = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  w_opcode;
    logic        w_br_taken;
    logic        w_reserved;
    logic        w_unused_ir;

    assign w_opcode    = ir[15:12];
    assign w_br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign w_unused_ir = ^{ir[8:6], ir[4:0]};

`ifdef PUNC_ILLEGAL_HALT_EN
    assign w_reserved = (w_opcode == 4'b1000) || (w_opcode == 4'b1101);
`else
    assign w_reserved = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef PUNC_ILLEGAL_HALT_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_EXEC && w_reserved) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`endif

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_opcode == HALT_OPCODE || w_reserved) begin
                    w_next = S_HALT;
                end else if (w_opcode == OP_LDI || w_opcode == OP_STI) begin
                    w_next = S_EXEC2;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC2:  w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 2'd0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_w_addr_sel    = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        ldi_reg_ld       = 1'b0;
        halted           = 1'b0;

        // Reset overrides the state decode so an in-flight instruction writes nothing.
        if (rst) begin
            pc_clr = 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    mem_r_addr_sel = 2'd0;
                    ir_ld          = 1'b1;
                end
                S_DECODE: begin
                    pc_inc = 1'b1;
                end
                S_EXEC: begin
                    case (w_opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            rf_w_en       = 1'b1;
                            rf_w_data_sel = 2'd0;
                            cond_ld       = 1'b1;
                            if (w_opcode == OP_NOT) begin
                                alu_sel = ALU_NOT;
                            end else if (w_opcode == OP_ADD) begin
                                alu_sel = ir[5] ? ALU_ADDI : ALU_ADD;
                            end else begin
                                alu_sel = ir[5] ? ALU_ANDI : ALU_AND;
                            end
                        end
                        OP_BR: begin
                            pc_ld = w_br_taken;
                        end
                        OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                        end
                        // R7 and PC update on the same edge, so JSRR through R7 reads the old link.
                        OP_JSR: begin
                            rf_w_en        = 1'b1;
                            rf_w_addr_sel  = 1'b1;
                            rf_w_data_sel  = 2'd2;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        OP_LD, OP_LDR: begin
                            mem_r_addr_sel   = (w_opcode == OP_LD) ? 2'd1 : 2'd2;
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_LEA: begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd3;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_ST: begin
                            rf_r0_addr_sel = 1'b1;
                            mem_w_en       = 1'b1;
                        end
                        OP_STR: begin
                            rf_r0_addr_sel = 1'b1;
                            rf_r1_addr_sel = 1'b1;
                            mem_w_addr_sel = 2'd1;
                            mem_w_en       = 1'b1;
                        end
                        OP_LDI: begin
                            mem_r_addr_sel = 2'd1;
                            ldi_reg_ld     = 1'b1;
                        end
                        OP_STI: begin
                            mem_r_addr_sel = 2'd1;
                        end
                        default: begin
                        end
                    endcase
                end
                S_EXEC2: begin
                    if (w_opcode == OP_LDI) begin
                        mem_r_addr_sel   = 2'd3;
                        rf_w_en          = 1'b1;
                        rf_w_data_sel    = 2'd1;
                        cond_ld          = 1'b1;
                        cond_ld_data_sel = 1'b1;
                    end else begin
                        // STI: pointer word is still on mem_r_data, so it becomes the write address.
                        mem_r_addr_sel = 2'd1;
                        mem_w_addr_sel = 2'd2;
                        rf_r0_addr_sel = 1'b1;
                        mem_w_en       = 1'b1;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// Directed-vector bench for punc_control: driver queues the expected control word per cycle, monitor compares at negedge.
module tb_punc_control;

    typedef struct packed {
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       ldi_reg_ld;
        logic       halted;
`ifdef PUNC_ILLEGAL_HALT_EN
        logic       illegal;
`endif
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;
    logic        mem_w_en, mem_w_data_sel, rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_addr_sel;
    logic        ir_ld, pc_ld, pc_clr, pc_inc, cond_ld, cond_ld_data_sel, ldi_reg_ld, halted;
    logic [1:0]  mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic [2:0]  alu_sel;
`ifdef PUNC_ILLEGAL_HALT_EN
    logic        illegal;
`endif

    int total = 0;
    int bad = 0;
    outs_t exp_q[$];
    string nm_q[$];
    outs_t act;

    always #5 clk = ~clk;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel), .mem_w_data_sel(mem_w_data_sel),
        .mem_r_addr_sel(mem_r_addr_sel), .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel),
        .alu_sel(alu_sel), .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel), .ldi_reg_ld(ldi_reg_ld),
`ifdef PUNC_ILLEGAL_HALT_EN
        .illegal(illegal),
`endif
        .halted(halted)
    );

    always_comb begin
        act = '0;
        act.mem_w_en = mem_w_en;             act.mem_w_addr_sel = mem_w_addr_sel;
        act.mem_w_data_sel = mem_w_data_sel; act.mem_r_addr_sel = mem_r_addr_sel;
        act.rf_w_en = rf_w_en;               act.rf_r0_addr_sel = rf_r0_addr_sel;
        act.rf_r1_addr_sel = rf_r1_addr_sel; act.rf_w_data_sel = rf_w_data_sel;
        act.rf_w_addr_sel = rf_w_addr_sel;   act.ir_ld = ir_ld;
        act.pc_ld = pc_ld;                   act.pc_clr = pc_clr;
        act.pc_inc = pc_inc;                 act.pc_ld_data_sel = pc_ld_data_sel;
        act.alu_sel = alu_sel;               act.cond_ld = cond_ld;
        act.cond_ld_data_sel = cond_ld_data_sel;
        act.ldi_reg_ld = ldi_reg_ld;         act.halted = halted;
`ifdef PUNC_ILLEGAL_HALT_EN
        act.illegal = illegal;
`endif
    end

    // Monitor: one expected control word per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t e;
            string s;
            e = exp_q.pop_front();
            s = nm_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h", s, act, e);
            end
        end
    end

    task automatic step(input logic r, input logic [15:0] i, input logic [2:0] nzp,
                        input outs_t e, input string nm);
        @(posedge clk);
        #1;
        rst = r;
        ir = i;
        {n, z, p} = nzp;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic fd(input logic [15:0] i, input logic [2:0] nzp, input string nm);
        outs_t e;
        e = '0; e.ir_ld = 1'b1;
        step(1'b0, i, nzp, e, {nm, "_fetch"});
        e = '0; e.pc_inc = 1'b1;
        step(1'b0, i, nzp, e, {nm, "_decode"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        outs_t e;
        outs_t e_rst;
        e_rst = '0; e_rst.pc_clr = 1'b1;

        step(1'b1, 16'h0000, 3'b000, e_rst, "reset_c0");
        step(1'b1, 16'h0000, 3'b000, e_rst, "reset_c1");

        // ADD R1,R1,#1
        fd(16'h1261, 3'b000, "add_imm");
        e = '0; e.rf_w_en = 1; e.alu_sel = 3'd1; e.cond_ld = 1;
        step(1'b0, 16'h1261, 3'b000, e, "add_imm_exec");

        // AND R0,R1,R2 (register form) and NOT R0,R0
        fd(16'h5042, 3'b000, "and_reg");
        e = '0; e.rf_w_en = 1; e.alu_sel = 3'd3; e.cond_ld = 1;
        step(1'b0, 16'h5042, 3'b000, e, "and_reg_exec");
        fd(16'h903F, 3'b000, "not");
        e = '0; e.rf_w_en = 1; e.alu_sel = 3'd2; e.cond_ld = 1;
        step(1'b0, 16'h903F, 3'b000, e, "not_exec");

        // BRz taken (z=1) and not taken (n=1)
        fd(16'h0402, 3'b010, "brz_t");
        e = '0; e.pc_ld = 1;
        step(1'b0, 16'h0402, 3'b010, e, "brz_taken_exec");
        fd(16'h0402, 3'b100, "brz_nt");
        e = '0;
        step(1'b0, 16'h0402, 3'b100, e, "brz_not_taken_exec");

        // LDI R1, #1
        fd(16'hA201, 3'b000, "ldi");
        e = '0; e.mem_r_addr_sel = 2'd1; e.ldi_reg_ld = 1;
        step(1'b0, 16'hA201, 3'b000, e, "ldi_exec");
        e = '0; e.mem_r_addr_sel = 2'd3; e.rf_w_en = 1; e.rf_w_data_sel = 2'd1;
        e.cond_ld = 1; e.cond_ld_data_sel = 1;
        step(1'b0, 16'hA201, 3'b000, e, "ldi_exec2");

        // STI R1, #1 followed directly by JSR #5
        fd(16'hB201, 3'b000, "sti");
        e = '0; e.mem_r_addr_sel = 2'd1;
        step(1'b0, 16'hB201, 3'b000, e, "sti_exec");
        e = '0; e.mem_r_addr_sel = 2'd1; e.mem_w_addr_sel = 2'd2; e.rf_r0_addr_sel = 1; e.mem_w_en = 1;
        step(1'b0, 16'hB201, 3'b000, e, "sti_exec2");
        fd(16'h4805, 3'b000, "jsr");
        e = '0; e.rf_w_en = 1; e.rf_w_addr_sel = 1; e.rf_w_data_sel = 2'd2; e.pc_ld = 1; e.pc_ld_data_sel = 2'd2;
        step(1'b0, 16'h4805, 3'b000, e, "jsr_exec");

        // JSRR R2, JMP R7
        fd(16'h4080, 3'b000, "jsrr");
        e = '0; e.rf_w_en = 1; e.rf_w_addr_sel = 1; e.rf_w_data_sel = 2'd2; e.pc_ld = 1; e.pc_ld_data_sel = 2'd1;
        step(1'b0, 16'h4080, 3'b000, e, "jsrr_exec");
        fd(16'hC1C0, 3'b000, "jmp");
        e = '0; e.pc_ld = 1; e.pc_ld_data_sel = 2'd1;
        step(1'b0, 16'hC1C0, 3'b000, e, "jmp_exec");

        // LD, LDR, LEA
        fd(16'h2205, 3'b000, "ld");
        e = '0; e.mem_r_addr_sel = 2'd1; e.rf_w_en = 1; e.rf_w_data_sel = 2'd1; e.cond_ld = 1; e.cond_ld_data_sel = 1;
        step(1'b0, 16'h2205, 3'b000, e, "ld_exec");
        fd(16'h6245, 3'b000, "ldr");
        e = '0; e.mem_r_addr_sel = 2'd2; e.rf_w_en = 1; e.rf_w_data_sel = 2'd1; e.cond_ld = 1; e.cond_ld_data_sel = 1;
        step(1'b0, 16'h6245, 3'b000, e, "ldr_exec");
        fd(16'hE205, 3'b000, "lea");
        e = '0; e.rf_w_en = 1; e.rf_w_data_sel = 2'd3; e.cond_ld = 1; e.cond_ld_data_sel = 1;
        step(1'b0, 16'hE205, 3'b000, e, "lea_exec");

        // ST, STR
        fd(16'h3205, 3'b000, "st");
        e = '0; e.rf_r0_addr_sel = 1; e.mem_w_en = 1;
        step(1'b0, 16'h3205, 3'b000, e, "st_exec");
        fd(16'h7245, 3'b000, "str");
        e = '0; e.rf_r0_addr_sel = 1; e.rf_r1_addr_sel = 1; e.mem_w_addr_sel = 2'd1; e.mem_w_en = 1;
        step(1'b0, 16'h7245, 3'b000, e, "str_exec");

        // Reset during EXEC of an ADD: no write, restart at FETCH
        fd(16'h1261, 3'b000, "abort");
        step(1'b1, 16'h1261, 3'b000, e_rst, "abort_rst");
        e = '0; e.ir_ld = 1;
        step(1'b0, 16'h1261, 3'b000, e, "abort_refetch");
        e = '0; e.pc_inc = 1;
        step(1'b0, 16'h1261, 3'b000, e, "abort_decode");
        e = '0; e.rf_w_en = 1; e.alu_sel = 3'd1; e.cond_ld = 1;
        step(1'b0, 16'h1261, 3'b000, e, "abort_exec");

`ifndef PUNC_ILLEGAL_HALT_EN
        // Reserved opcodes behave as NOPs
        fd(16'h8000, 3'b000, "rsv8");
        e = '0;
        step(1'b0, 16'h8000, 3'b000, e, "rsv8_exec");
        fd(16'hD000, 3'b000, "rsvd");
        e = '0;
        step(1'b0, 16'hD000, 3'b000, e, "rsvd_exec");
`endif

        // HALT: stays halted until reset
        fd(16'hF025, 3'b000, "halt");
        e = '0;
        step(1'b0, 16'hF025, 3'b000, e, "halt_exec");
        e = '0; e.halted = 1;
        for (int k = 0; k < 10; k++) step(1'b0, 16'hF025, 3'b111, e, "halt_hold");
        step(1'b1, 16'hF025, 3'b000, e_rst, "halt_rst");
        e = '0; e.ir_ld = 1;
        step(1'b0, 16'h1261, 3'b000, e, "post_halt_fetch");

`ifdef PUNC_ILLEGAL_HALT_EN
        // Reserved opcode traps: illegal rises on entry to HALT, clears after reset edge
        e = '0; e.pc_inc = 1;
        step(1'b0, 16'h8000, 3'b000, e, "ill_decode");
        e = '0;
        step(1'b0, 16'h8000, 3'b000, e, "ill_exec");
        e = '0; e.halted = 1; e.illegal = 1;
        for (int k = 0; k < 3; k++) step(1'b0, 16'h8000, 3'b000, e, "ill_halt");
        e = e_rst; e.illegal = 1;
        step(1'b1, 16'h8000, 3'b000, e, "ill_rst");
        e = '0; e.ir_ld = 1;
        step(1'b0, 16'h8000, 3'b000, e, "ill_cleared_fetch");
`endif

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
